// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared sample code space and meter state encoding
package wave_pkg;

    // Sample width and midscale code, shared with the waveform generators.
    localparam int DATA_W = 14;
    localparam logic [DATA_W-1:0] MID = 14'd8192;

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SYNC = 2'd2,
        MEAS = 2'd3
    } state_t;

endpackage

// File: rtl/wave_meter_if.sv
// rtl/wave_meter_if.sv - ADC sample stream in, measurement results out
//   master: drives adc_valid/adc_data, receives results
//   slave : the meter; consumes samples, drives period/vmax/vmin/vpp/meas_valid/no_signal
interface wave_meter_if #(
    parameter int CNT_W = 24
);
    import wave_pkg::*;

    logic              adc_valid;
    sample_t           adc_data;
    logic [CNT_W-1:0]  period;
    sample_t           vmax;
    sample_t           vmin;
    sample_t           vpp;
    logic              meas_valid;
    logic              no_signal;

    modport master (
        output adc_valid, adc_data,
        input  period, vmax, vmin, vpp, meas_valid, no_signal
    );

    modport slave (
        input  adc_valid, adc_data,
        output period, vmax, vmin, vpp, meas_valid, no_signal
    );

endinterface

// File: rtl/wave_meter_schmitt_edge.sv
// rtl/wave_meter_schmitt_edge.sv - Schmitt level tracker with rising-edge flag
//   clk, rst_n         : clock, synchronous active-low reset
//   adc_valid/adc_data : sample stream; level only moves on accepted samples
//   level_next         : level after the current sample (combinational)
//   rise               : current accepted sample moves the level 0->1
module schmitt_edge
    import wave_pkg::*;
#(
    parameter int HYST = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    adc_valid,
    input  sample_t adc_data,
    output logic    level_next,
    output logic    rise
);

    localparam sample_t TH_HI = sample_t'(int'(MID) + HYST);
    localparam sample_t TH_LO = sample_t'(int'(MID) - HYST);

    logic level;

    always_comb begin
        level_next = level;
        if (adc_valid) begin
            if (adc_data >= TH_HI) begin
                level_next = 1'b1;
            end else if (adc_data <= TH_LO) begin
                level_next = 1'b0;
            end
        end
    end

    assign rise = ~level & level_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= 1'b0;
        end else begin
            level <= level_next;
        end
    end

endmodule

// File: rtl/wave_meter.sv
// rtl/wave_meter.sv - period and amplitude meter for the AWG loopback path
//   clk, rst_n : clock, synchronous active-low reset
//   en         : measurement enable; low returns to IDLE and clears no_signal
//   bus        : slave side of wave_meter_if (samples in, results out)
module wave_meter
    import wave_pkg::*;
#(
    parameter int               HYST    = 64,
    parameter int               NPER    = 4,
    parameter int               CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(24'hFFFFFF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    wave_meter_if.slave  bus
);

    state_t           state, state_nxt;
    logic             level_next, rise;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [CNT_W-1:0] since_edge, since_inc;
    logic [7:0]       per, per_inc;
    sample_t          cur_min, cur_max, min_nxt, max_nxt;
    logic [CNT_W-1:0] period_r;
    sample_t          vmin_r, vmax_r, vpp_r;
    logic             meas_valid_r, no_signal_r;

    logic acc, timeout_hit, start, meas_edge, done, timeout_fire;

    schmitt_edge #(.HYST(HYST)) u_schmitt (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_valid  (bus.adc_valid),
        .adc_data   (bus.adc_data),
        .level_next (level_next),
        .rise       (rise)
    );

    assign acc         = bus.adc_valid;
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
    assign since_inc   = since_edge + 1'b1;
    assign per_inc     = per + 8'd1;
    assign timeout_hit = (since_inc == TIMEOUT);
    assign min_nxt     = (bus.adc_data < cur_min) ? bus.adc_data : cur_min;
    assign max_nxt     = (bus.adc_data > cur_max) ? bus.adc_data : cur_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (en) state_nxt = ARM;
            ARM:  if (acc && !level_next) state_nxt = SYNC;
            SYNC: begin
                if (rise)                    state_nxt = MEAS;
                else if (acc && timeout_hit) state_nxt = ARM;
            end
            MEAS: if (acc && !rise && timeout_hit) state_nxt = ARM;
        endcase
        if (!en) state_nxt = IDLE;
    end

    // A completing edge restarts the window exactly like the SYNC edge, so
    // back-to-back measurements share their boundary sample.
    always_comb begin
        start        = (state == SYNC) && rise;
        meas_edge    = (state == MEAS) && rise;
        done         = meas_edge && (per_inc == 8'(NPER));
        timeout_fire = ((state == SYNC) || (state == MEAS)) && acc && !rise && timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            since_edge   <= '0;
            per          <= '0;
            cur_min      <= '0;
            cur_max      <= '0;
            period_r     <= '0;
            vmin_r       <= '0;
            vmax_r       <= '0;
            vpp_r        <= '0;
            meas_valid_r <= 1'b0;
            no_signal_r  <= 1'b0;
        end else begin
            meas_valid_r <= done;
            if (done) begin
                period_r <= cnt_inc;
                vmin_r   <= min_nxt;
                vmax_r   <= max_nxt;
                vpp_r    <= max_nxt - min_nxt;
            end

            if (!en || done) begin
                no_signal_r <= 1'b0;
            end else if (timeout_fire) begin
                no_signal_r <= 1'b1;
            end

            if (start || done) begin
                cnt        <= '0;
                per        <= '0;
                cur_min    <= bus.adc_data;
                cur_max    <= bus.adc_data;
                since_edge <= '0;
            end else if (meas_edge) begin
                per        <= per_inc;
                cnt        <= cnt_inc;
                cur_min    <= min_nxt;
                cur_max    <= max_nxt;
                since_edge <= '0;
            end else if ((state == MEAS) && acc) begin
                cnt        <= cnt_inc;
                cur_min    <= min_nxt;
                cur_max    <= max_nxt;
                since_edge <= since_inc;
            end else if ((state == SYNC) && acc) begin
                since_edge <= since_inc;
            end else if ((state == IDLE) || (state == ARM)) begin
                since_edge <= '0;
            end
        end
    end

    assign bus.period     = period_r;
    assign bus.vmin       = vmin_r;
    assign bus.vmax       = vmax_r;
    assign bus.vpp        = vpp_r;
    assign bus.meas_valid = meas_valid_r;
    assign bus.no_signal  = no_signal_r;

endmodule

// File: tb/tb_wave_meter.sv
// tb/tb_wave_meter.sv - scoreboard bench for wave_meter
module tb_wave_meter;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    int   cyc = 0;

    wave_meter_if #(.CNT_W(24)) bus ();

    wave_meter #(.TIMEOUT(24'd1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int period;
        int vmin;
        int vmax;
    } res_t;

    res_t exp_q[$];
    int   pulse_t[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every meas_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (bus.meas_valid) begin
            pulse_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_meas_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("period", int'(bus.period), e.period);
                check("vmin",   int'(bus.vmin),   e.vmin);
                check("vmax",   int'(bus.vmax),   e.vmax);
                check("vpp",    int'(bus.vpp),    e.vmax - e.vmin);
            end
        end
    end

    task automatic expect_res(input int p, input int lo, input int hi);
        res_t r;
        r.period = p;
        r.vmin   = lo;
        r.vmax   = hi;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int d, input int idle);
        bus.adc_valid = 1'b1;
        bus.adc_data  = 14'(d);
        tick();
        bus.adc_valid = 1'b0;
        for (int i = 0; i < idle; i++) tick();
    endtask

    task automatic square(input int p, input int n, input bit hi_first);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                if ((i < p / 2) ^ hi_first) sample(0, 0);
                else                        sample(16383, 0);
            end
        end
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_period",     int'(bus.period),     0);
        check("rst_vmin",       int'(bus.vmin),       0);
        check("rst_vmax",       int'(bus.vmax),       0);
        check("rst_vpp",        int'(bus.vpp),        0);
        check("rst_meas_valid", int'(bus.meas_valid), 0);
        check("rst_no_signal",  int'(bus.no_signal),  0);
        en = 1'b1;
        tick();

        // 1: full-scale square, P=100, two back-to-back results
        expect_res(400, 0, 16383);
        expect_res(400, 0, 16383);
        square(100, 9, 1'b0);

        // 2: triangle 4096..12288, P=256, one sample every 3 clocks
        restart();
        pulse_t.delete();
        expect_res(1024, 4096, 12288);
        expect_res(1024, 4096, 12288);
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 256; i++) begin
                sample(4096 + 64 * ((i <= 128) ? i : 256 - i), 2);
            end
        end
        if (pulse_t.size() >= 2) begin
            check("tri_spacing", pulse_t[pulse_t.size()-1] - pulse_t[pulse_t.size()-2], 3072);
        end else begin
            check("tri_pulse_count", pulse_t.size(), 2);
        end

        // 3a: square with +/-50 noise bands through midscale, P=64
        restart();
        expect_res(256, 4096, 12288);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 28; i++) sample(4096, 0);
            for (int i = 0; i < 8; i++)  sample(8192 + ((i % 2) ? -50 : 50 - i), 0);
            for (int i = 0; i < 20; i++) sample(12288, 0);
            for (int i = 0; i < 8; i++)  sample(8192 + ((i % 2) ? 50 : -50 + i), 0);
        end

        // 3b: flat midscale noise -> timeout after exactly 1000 samples
        restart();
        sample(4096, 0);
        for (int k = 1; k <= 999; k++) sample(8192 + ((k * 37) % 101) - 50, 0);
        check("no_signal_before_timeout", int'(bus.no_signal), 0);
        sample(8192 + ((1000 * 37) % 101) - 50, 0);
        check("no_signal_at_timeout", int'(bus.no_signal), 1);
        tick();
        check("no_signal_sticky", int'(bus.no_signal), 1);

        // 4: en dropped mid-measurement, partial window discarded
        restart();
        check("no_signal_cleared_by_en", int'(bus.no_signal), 0);
        for (int i = 0; i < 50; i++) sample(0, 0);
        for (int i = 0; i < 50; i++) sample(16383, 0);
        for (int i = 0; i < 50; i++) sample(0, 0);
        restart();
        expect_res(400, 0, 16383);
        square(100, 5, 1'b0);

        // 5: reset pulse during MEAS clears outputs, then re-measure
        restart();
        square(100, 2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_period", int'(bus.period), 0);
        check("mid_rst_vmax",   int'(bus.vmax),   0);
        check("mid_rst_vpp",    int'(bus.vpp),    0);
        check("mid_rst_meas",   int'(bus.meas_valid), 0);
        tick();
        expect_res(400, 0, 16383);
        square(100, 5, 1'b0);

        // 6: waveform starts high; first counted edge is the second rise
        restart();
        expect_res(400, 0, 16383);
        square(100, 6, 1'b1);

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wave_meter.md
Name: wave_meter

Overview:
- Measurement end of the AWG output path: consumes 14-bit offset-binary ADC samples (midscale 8192, the same code space the generators drive into DAC_in) taken from a loopback of the DAC output.
- Reports period length in samples over NPER cycles, plus signal min, max and peak-to-peak.
- Used for self-test and closed-loop frequency and amplitude calibration of the generators.

Parameters:
- DATA_W, 14, sample width (offset binary).
- MID, 8192, zero-crossing reference code.
- HYST, 64, Schmitt hysteresis half-width; high threshold is MID+HYST, low threshold is MID-HYST.
- NPER, 4, number of full periods accumulated per measurement (1..255).
- CNT_W, 24, period accumulator width.
- TIMEOUT, 24'hFFFFFF, samples without a valid edge before signalling no_signal.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  measurement enable; low returns the block to IDLE.
- adc_valid  in  1  sample strobe; all counting is per accepted sample.
- adc_data  in  DATA_W  ADC sample.
- period  out  CNT_W  total samples spanning NPER periods.
- vmax  out  DATA_W  maximum sample in the measurement window.
- vmin  out  DATA_W  minimum sample in the measurement window.
- vpp  out  DATA_W  vmax-vmin.
- meas_valid  out  1  one-cycle pulse when results update.
- no_signal  out  1  sticky timeout flag; cleared at the next meas_valid or when en falls.

Behaviour:
- Reset: all outputs 0. State IDLE. Schmitt level 0, counters 0.
- Sample acceptance: a sample is accepted only when adc_valid=1. All state changes occur on accepted samples, except the en/reset exits.
- Schmitt level:
  - Goes to 1 when data >= MID+HYST.
  - Goes to 0 when data <= MID-HYST.
  - Otherwise holds.
  - A rising edge is an accepted sample that moves the level 0->1.
- States:
  - IDLE: wait for en=1, then go to ARM.
  - ARM: wait for level=0, then go to SYNC. A waveform already high must fall first.
  - SYNC: on a rising edge, clear cnt=0 and per=0, load min=max=data, go to MEAS.
  - MEAS:
    - Each accepted non-edge sample: cnt+=1, update min/max.
    - On a rising edge: per+=1, update min/max.
    - If per reaches NPER on that edge: capture period=cnt+1, vmin, vmax, vpp; pulse meas_valid the next cycle (latency 1 clk from the edge sample); clear no_signal. Then restart as if SYNC saw this edge (cnt=0, min=max=data), so measurements run back-to-back.
    - Otherwise on the edge: cnt+=1 and continue.
- Period convention: a square wave of P samples per period gives period = NPER*P exactly.
- Timeout: in SYNC or MEAS, if the count of accepted samples since the last edge (or since entering SYNC) reaches TIMEOUT:
  - Set no_signal=1, go to ARM.
  - Outputs other than no_signal hold their last values.
- Saturation: cnt saturates at all-ones. Timeout normally fires first.
- en low in any state: next clk go to IDLE, clear no_signal. Output values hold. A partial measurement is discarded.
- rst_n low mid-measurement: full reset of state and outputs on that clk edge.
- Simultaneous meas_valid capture and en falling: the capture completes, the pulse is still emitted, then IDLE.
- Arithmetic: min and max compare unsigned; vpp is an unsigned subtraction and is never negative since vmax >= vmin.

Decomposition:
- Shared package wave_pkg holds:
  - the state encoding (IDLE, ARM, SYNC, MEAS);
  - DATA_W and MID constants shared with the generators.
- One natural sub-module: schmitt_edge. It holds the level register and produces the rising-edge flag from adc_data, adc_valid and the thresholds.

Test Plan:
1. Square wave 0/16383, P=100, NPER=4, adc_valid=1 every cycle -> meas_valid every 400 samples. period=400, vmin=0, vmax=16383, vpp=16383.
2. Triangle 4096..12288, P=256, adc_valid every 3rd cycle -> period=1024, vmin=4096, vmax=12288, vpp=8192. Pulses spaced 3072 clks.
3. Noise +/-50 around 8192 superimposed on a square wave with P=64 -> no extra edges counted, period=256. Flat 8192 with +/-50 noise and small TIMEOUT=1000 -> no_signal=1 after 1000 samples, no meas_valid.
4. en dropped mid-MEAS after 150 samples, then re-raised -> no meas_valid from the partial window. First result after re-arm is a full period=400.
5. rst_n low for 1 clk during MEAS -> all outputs 0 on the next clk. Measurement restarts from ARM.
6. Signal starting high (first sample 16383) -> ARM waits for the low phase. The first counted edge is the second rising transition, and period=400.
